bcd_counter_nd: RTL and testbench

Parametrised N-digit BCD up/down counter with built-in tick prescaler and per-digit active-low 7-segment outputs. It generalises the single-digit 0–9 counter on HEX0 to any digit count, with load, enable, a wrap carry strobe and optional leading-zero blanking. The block sits between the board clock/switches and the HEX displays, and serves as the shared counting/display engine for timer and scoreboard exercises.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/bcd_digit.sv | 52 +++++
 rtl/bcd_counter_nd.sv | 106 ++++++++++
 tb/tb_bcd_counter_nd.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for HEX-driving blocks.
// Segment vectors are active-low and ordered {a,b,c,d,e,f,g}, so bit 6 is
// segment a and bit 0 is segment g.
//   SEG_0..SEG_9 : glyphs for the decimal digits
//   SEG_BLANK    : all segments off
//   bcd_to_seg7  : maps one BCD nibble to its glyph; non-BCD values are blank
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the ripple counter chain.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (decade returns to 0)
//   step     : step request for this decade (carry/borrow in from below)
//   up       : 1 = increment, 0 = decrement
//   load     : parallel load, overrides step
//   load_val : value to load; anything above 9 loads as 0
//   q        : current decade value, always 0..9
//   co       : carry/borrow out, asserted when this decade wraps on a step
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       co
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       at_limit;

    // The decade wraps when counting up from 9 or down from 0.
    assign at_limit = up ? (q_q == 4'd9) : (q_q == 4'd0);
    assign co       = step & at_limit;
    assign q        = q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val > 4'd9) ? 4'd0 : load_val;
        end else if (step) begin
            if (up) begin
                q_d = at_limit ? 4'd0 : q_q + 4'd1;
            end else begin
                q_d = at_limit ? 4'd9 : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with a free-running tick prescaler and
// per-digit active-low 7-segment outputs.
// Parameters:
//   DIGITS   : number of decades (1..8)
//   DIV      : clocks per count tick (>= 2)
//   BLANK_LZ : 1 blanks leading-zero digits above digit 0
// Ports:
//   CLOCK_50Mhz : clock, rising edge
//   RST         : synchronous active-high reset
//   EN          : allows a step on each tick
//   UP          : direction, sampled in the tick cycle
//   LOAD        : synchronous parallel load, beats a simultaneous step
//   LOAD_VAL    : BCD load value, digit k in [4k+3:4k]
//   BCD         : current count, digit k in [4k+3:4k]
//   HEX         : active-low segments, digit k in [7k+6:7k] (a at the top)
//   TICK        : one-cycle prescaler strobe
//   CARRY       : one-cycle strobe aligned with a wrapped count
module bcd_counter_nd
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV      = 50_000_000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  CLOCK_50Mhz,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  TICK,
    output logic                  CARRY
);

    localparam int              PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             carry_q;
    logic             carry_d;
    logic [DIGITS:0]  step;
    logic [DIGITS-1:0] blank;
    logic             zero_above;

    // Prescaler runs regardless of EN and LOAD; only reset restarts its phase.
    assign TICK = (pre_q == PRE_MAX);

    always_comb begin
        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    end

    // step[k] is the step request into decade k; step[DIGITS] is the wrap
    // out of the most significant decade.
    assign step[0] = EN & TICK;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit u_digit (
                .clk      (CLOCK_50Mhz),
                .rst      (RST),
                .step     (step[k]),
                .up       (UP),
                .load     (LOAD),
                .load_val (LOAD_VAL[4*k +: 4]),
                .q        (BCD[4*k +: 4]),
                .co       (step[k+1])
            );
        end
    endgenerate

    // A load drops the step entirely, so it must also suppress the wrap strobe.
    assign carry_d = step[DIGITS] & ~LOAD;
    assign CARRY   = carry_q;

    always_ff @(posedge CLOCK_50Mhz) begin
        if (RST) begin
            pre_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            carry_q <= carry_d;
        end
    end

    // Walk from the top decade down: a digit is blank while it and every
    // digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (BCD[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) & zero_above;
        end
    end

    generate
        for (k = 0; k < DIGITS; k++) begin : g_hex
            assign HEX[7*k +: 7] = blank[k] ? SEG_BLANK : bcd_to_seg7(BCD[4*k +: 4]);
        end
    endgenerate

endmodule

// File: tb/tb_bcd_counter_nd.sv
module tb_bcd_counter_nd;

    localparam int DIGITS = 3;
    localparam int DIV    = 4;
    localparam int MAXV   = 1000;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        UP = 1'b1;
    logic        LOAD = 1'b0;
    logic [11:0] LOAD_VAL = 12'h000;

    logic [11:0] bcd0, bcd1;
    logic [20:0] hex0, hex1;
    logic        tick0, tick1, carry0, carry1;

    int tests = 0;
    int fails = 0;

    // Behavioural model: count as a plain integer, prescaler phase as an integer.
    int m_cnt = 0;
    int m_pre = 0;
    bit m_carry = 0;
    bit m_ticked = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clk = ~clk;

    bcd_counter_nd #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_LZ(0)) dut0 (
        .CLOCK_50Mhz (clk),
        .RST         (RST),
        .EN          (EN),
        .UP          (UP),
        .LOAD        (LOAD),
        .LOAD_VAL    (LOAD_VAL),
        .BCD         (bcd0),
        .HEX         (hex0),
        .TICK        (tick0),
        .CARRY       (carry0)
    );

    bcd_counter_nd #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_LZ(1)) dut1 (
        .CLOCK_50Mhz (clk),
        .RST         (RST),
        .EN          (EN),
        .UP          (UP),
        .LOAD        (LOAD),
        .LOAD_VAL    (LOAD_VAL),
        .BCD         (bcd1),
        .HEX         (hex1),
        .TICK        (tick1),
        .CARRY       (carry1)
    );

    function automatic int load_dec(input logic [11:0] v);
        int sum = 0;
        int p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            int d = int'(v[4*k +: 4]);
            if (d > 9) d = 0;
            sum += d * p;
            p *= 10;
        end
        return sum;
    endfunction

    function automatic logic [11:0] to_bcd(input int c);
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [20:0] hex_exp(input int c, input bit blz);
        logic [20:0] h;
        int p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (blz && k > 0 && c < p) h[7*k +: 7] = 7'b1111111;
            else                       h[7*k +: 7] = seg_tab[(c / p) % 10];
            p *= 10;
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check #1 later.
    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [11:0] v);
        RST = r; EN = e; UP = u; LOAD = l; LOAD_VAL = v;
        @(posedge clk);
        m_ticked = 0;
        if (r) begin
            m_cnt = 0; m_pre = 0; m_carry = 0;
        end else begin
            m_ticked = (m_pre == DIV - 1);
            m_pre    = (m_pre + 1) % DIV;
            m_carry  = 0;
            if (l) begin
                m_cnt = load_dec(v);
            end else if (e && m_ticked) begin
                if (u) begin
                    m_carry = (m_cnt == MAXV - 1);
                    m_cnt   = (m_cnt + 1) % MAXV;
                end else begin
                    m_carry = (m_cnt == 0);
                    m_cnt   = (m_cnt + MAXV - 1) % MAXV;
                end
            end
        end
        #1;
        chk("bcd0",   32'(bcd0),   32'(to_bcd(m_cnt)));
        chk("bcd1",   32'(bcd1),   32'(to_bcd(m_cnt)));
        chk("tick0",  32'(tick0),  32'(m_pre == DIV - 1));
        chk("tick1",  32'(tick1),  32'(m_pre == DIV - 1));
        chk("carry0", 32'(carry0), 32'(m_carry));
        chk("carry1", 32'(carry1), 32'(m_carry));
        chk("hex0",   32'(hex0),   32'(hex_exp(m_cnt, 1'b0)));
        chk("hex1",   32'(hex1),   32'(hex_exp(m_cnt, 1'b1)));
    endtask

    initial begin
        int ticks;
        logic [11:0] held;

        // Reset state
        cyc(1, 0, 1, 0, 12'h000);
        cyc(1, 0, 1, 0, 12'h000);
        chk("rst_bcd",   32'(bcd0),   32'h000);
        chk("rst_tick",  32'(tick0),  32'h0);
        chk("rst_carry", 32'(carry0), 32'h0);
        chk("rst_hex0",  32'(hex0),   32'({7'b0000001, 7'b0000001, 7'b0000001}));
        chk("rst_hex1",  32'(hex1),   32'({7'b1111111, 7'b1111111, 7'b0000001}));

        // Count up for 40 cycles: ticks at cycles 4, 8, 12, ...
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1, 1, 0, 12'h000);
            chk("tick_period", 32'(tick0), 32'(((i + 1) % 4) == 0));
            if (bcd0 == 12'h009) chk("hex_nine", 32'(hex0[6:0]), 32'(7'b0000100));
        end
        chk("up_40", 32'(bcd0), 32'h010);

        // Wrap up from 999, then wrap down from 000
        cyc(0, 0, 1, 1, 12'h999);
        for (int i = 0; i < 2 * DIV; i++) begin
            cyc(0, 1, 1, 0, 12'h000);
            if (m_ticked) break;
        end
        chk("wrap_up_bcd",   32'(bcd0),   32'h000);
        chk("wrap_up_carry", 32'(carry0), 32'h1);
        cyc(0, 0, 1, 0, 12'h000);
        chk("carry_one_cycle", 32'(carry0), 32'h0);
        for (int i = 0; i < 2 * DIV; i++) begin
            cyc(0, 1, 0, 0, 12'h000);
            if (m_ticked) break;
        end
        chk("wrap_dn_bcd",   32'(bcd0),   32'h999);
        chk("wrap_dn_carry", 32'(carry0), 32'h1);

        // Invalid middle digit loads as 0
        cyc(0, 0, 1, 1, 12'h1A5);
        chk("load_invalid", 32'(bcd0), 32'h105);

        // LOAD in a TICK cycle wins and the step is dropped
        cyc(0, 0, 1, 1, 12'h050);
        for (int i = 0; i < DIV && m_pre != DIV - 1; i++) cyc(0, 0, 1, 0, 12'h000);
        chk("at_tick", 32'(tick0), 32'h1);
        cyc(0, 1, 1, 1, 12'h123);
        chk("load_vs_tick", 32'(bcd0), 32'h123);
        cyc(0, 0, 1, 0, 12'h000);
        chk("no_deferred_step", 32'(bcd0), 32'h123);

        // EN=0: hold, ticks continue, no carry
        held  = bcd0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 0, 12'h000);
            chk("hold_bcd", 32'(bcd0), 32'(held));
            if (tick0) ticks++;
        end
        chk("hold_ticks", 32'(ticks), 32'd5);

        // Leading-zero blanking
        cyc(0, 0, 1, 1, 12'h007);
        chk("blank_007", 32'(hex1), 32'({7'b1111111, 7'b1111111, 7'b0001111}));
        cyc(0, 0, 1, 1, 12'h000);
        chk("blank_000", 32'(hex1), 32'({7'b1111111, 7'b1111111, 7'b0000001}));
        cyc(0, 0, 1, 1, 12'h304);
        chk("noblank_304", 32'(hex1), 32'({7'b0000110, 7'b0000001, 7'b1001100}));

        // Reset mid-interval restarts the prescaler phase
        cyc(0, 0, 1, 1, 12'h456);
        for (int i = 0; i < DIV && m_pre != 1; i++) cyc(0, 1, 1, 0, 12'h000);
        cyc(1, 1, 1, 0, 12'h000);
        chk("rst_mid_bcd", 32'(bcd0), 32'h000);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 0, 12'h000);
            chk("tick_restart", 32'(tick0), 32'(i == 3));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
                ($urandom_range(15) == 0), 12'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
